// File: rtl/mvm_engine_p.sv
// Parametrised matrix-vector engine: loads C then X over valid/ready, computes y[r] = sum_c X[r][c]*C[c]
// with one MAC per cycle, and serves results by index. Optional macro SAT_EN selects saturating result storage.
module mvm_engine_p #(
  parameter int DATA_W = 8,
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  parameter int RES_W  = 18,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              valid_input,
  input  logic [DATA_W-1:0] X_load,
  output logic              load_ready,
  input  logic              read_n,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              ry,
  output logic [RES_W-1:0]  read_data,
  output logic              finish
);

  localparam int CW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int RW    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int ACC_W = 2 * DATA_W + CW;
  localparam int PW    = 2 * DATA_W;
  localparam int WIDE  = (RES_W > ACC_W) ? RES_W : ACC_W;

  localparam logic [CW-1:0]     COL_LAST = CW'(N_COLS - 1);
  localparam logic [RW-1:0]     ROW_LAST = RW'(N_ROWS - 1);
  localparam logic [ADDR_W:0]   ROWS_LIM = (ADDR_W + 1)'(N_ROWS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_C  = 3'd1,
    S_LOAD_X  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_c [N_COLS];
  logic [DATA_W-1:0] r_x [N_ROWS][N_COLS];
  logic [RES_W-1:0]  r_mem [N_ROWS];
  logic [ACC_W-1:0]  r_acc;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic              r_load_ready;
  logic              r_finish;
  logic              r_ry;
  logic [RES_W-1:0]  r_read_data;

  logic              w_accept;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_idle_done;
  logic [PW-1:0]     w_product;
  logic [ACC_W-1:0]  w_sum;

  // Narrow the accumulator sum to the stored width (wrap, or clamp when SAT_EN).
  function automatic logic [RES_W-1:0] f_store(input logic [ACC_W-1:0] sum);
    logic [WIDE-1:0] wide_sum;
    wide_sum = WIDE'(sum);
`ifdef SAT_EN
    if (wide_sum > WIDE'({RES_W{1'b1}})) begin
      return {RES_W{1'b1}};
    end
`endif
    return wide_sum[RES_W-1:0];
  endfunction

  assign w_accept    = valid_input && r_load_ready;
  assign w_col_last  = (r_col == COL_LAST);
  assign w_row_last  = (r_row == ROW_LAST);
  assign w_idle_done = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_product   = PW'(r_x[r_row][r_col]) * PW'(r_c[r_col]);
  assign w_sum       = r_acc + ACC_W'(w_product);

  assign load_ready = r_load_ready;
  assign finish     = r_finish;
  assign ry         = r_ry;
  assign read_data  = r_read_data;

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_in) w_next = S_LOAD_C;
        else          w_next = r_state;
      end
      S_LOAD_C: begin
        if (w_accept && w_col_last) w_next = S_LOAD_X;
        else                        w_next = S_LOAD_C;
      end
      S_LOAD_X: begin
        if (w_accept && w_col_last && w_row_last) w_next = S_COMPUTE;
        else                                      w_next = S_LOAD_X;
      end
      S_COMPUTE: begin
        if (w_col_last && w_row_last) w_next = S_DONE;
        else                          w_next = S_COMPUTE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, status flags, indices, accumulator and result store.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_load_ready <= 1'b0;
      r_finish     <= 1'b0;
      r_acc        <= '0;
      r_col        <= '0;
      r_row        <= '0;
      for (int i = 0; i < N_ROWS; i++) r_mem[i] <= '0;
    end else begin
      r_state      <= w_next;
      r_load_ready <= (w_next == S_LOAD_C) || (w_next == S_LOAD_X);
      r_finish     <= (w_next == S_DONE);
      case (r_state)
        S_LOAD_C: begin
          if (w_accept) r_col <= w_col_last ? '0 : r_col + CW'(1);
        end
        S_LOAD_X: begin
          if (w_accept) begin
            r_col <= w_col_last ? '0 : r_col + CW'(1);
            if (w_col_last) r_row <= w_row_last ? '0 : r_row + RW'(1);
          end
        end
        S_COMPUTE: begin
          r_col <= w_col_last ? '0 : r_col + CW'(1);
          if (w_col_last) begin
            r_row        <= w_row_last ? '0 : r_row + RW'(1);
            r_mem[r_row] <= f_store(w_sum);
            r_acc        <= '0;
          end else begin
            r_acc <= w_sum;
          end
        end
        default: begin
          r_col <= '0;
          r_row <= '0;
          r_acc <= '0;
        end
      endcase
    end
  end

  // Operand buffers hold whatever was last loaded; they are never read before being filled.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD_C && w_accept) begin
      r_c[r_col] <= X_load;
    end else if (r_state == S_LOAD_X && w_accept) begin
      r_x[r_row][r_col] <= X_load;
    end
  end

  // Read port: one-cycle latency, only while not busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ry        <= 1'b0;
      r_read_data <= '0;
    end else if (w_idle_done && !read_n) begin
      r_ry        <= 1'b1;
      r_read_data <= ({1'b0, r_addr} < ROWS_LIM) ? r_mem[r_addr[RW-1:0]] : '0;
    end else begin
      r_ry <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mvm_engine_p.sv
// Randomized self-checking bench for mvm_engine_p; a second instance with RES_W=10 exercises narrowing.
module tb_mvm_engine_p;

  logic        clk = 1'b0;
  logic        rst, start_in, valid_input, read_n;
  logic [7:0]  X_load, r_addr;
  logic        load_ready, ry, finish;
  logic [17:0] read_data;
  logic        load_ready10, ry10, finish10;
  logic [9:0]  read_data10;

  int n_vec = 0;
  int n_err = 0;
  int mc[4];
  int mx[4][4];

  always #5 clk = ~clk;

  mvm_engine_p dut (
    .clk(clk), .rst(rst), .start_in(start_in), .valid_input(valid_input), .X_load(X_load),
    .load_ready(load_ready), .read_n(read_n), .r_addr(r_addr), .ry(ry), .read_data(read_data),
    .finish(finish)
  );

  mvm_engine_p #(.RES_W(10)) dut10 (
    .clk(clk), .rst(rst), .start_in(start_in), .valid_input(valid_input), .X_load(X_load),
    .load_ready(load_ready10), .read_n(read_n), .r_addr(r_addr), .ry(ry10), .read_data(read_data10),
    .finish(finish10)
  );

  // Reference: full dot product, reduced to an 18-bit accumulator, then stored at res_w bits.
  function automatic int model_row(int r, int res_w);
    longint s = 0;
    for (int c = 0; c < 4; c++) s += longint'(mx[r][c]) * longint'(mc[c]);
    s = s % (longint'(1) << 18);
    if (res_w >= 18) return int'(s);
`ifdef SAT_EN
    if (s > (longint'(1) << res_w) - 1) return int'((longint'(1) << res_w) - 1);
`endif
    return int'(s % (longint'(1) << res_w));
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_fixed();
    for (int c = 0; c < 4; c++) mc[c] = c + 1;
    for (int c = 0; c < 4; c++) begin
      mx[0][c] = 1; mx[1][c] = 255; mx[2][c] = 0; mx[3][c] = 4 - c;
    end
  endtask

  task automatic set_random();
    for (int c = 0; c < 4; c++) mc[c] = int'($urandom_range(0, 255));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mx[r][c] = int'($urandom_range(0, 255));
  endtask

  // Feed C then X (optionally stalling), then count cycles until finish (optionally poking while busy).
  task automatic feed(input bit stall, input bit busy, output int lat, output int rdy_low, output int busy_ry);
    rdy_low = 0; busy_ry = 0;
    for (int w = 0; w < 20; w++) begin
      if (stall) begin
        valid_input = 1'b0; X_load = 8'hA5;
        if (!load_ready) rdy_low++;
        tick();
      end
      if (!load_ready) rdy_low++;
      valid_input = 1'b1;
      X_load = (w < 4) ? 8'(mc[w]) : 8'(mx[(w - 4) / 4][(w - 4) % 4]);
      tick();
    end
    valid_input = 1'b0;
    lat = 1;
    while (!finish && lat < 100) begin
      if (busy && lat < 10) begin read_n = 1'b0; start_in = 1'b1; r_addr = 8'(lat % 4); end
      else begin read_n = 1'b1; start_in = 1'b0; end
      tick();
      if (ry || ry10) busy_ry++;
      lat++;
    end
    read_n = 1'b1; start_in = 1'b0;
  endtask

  task automatic run_load(input bit stall, input bit busy, output int lat, output int rdy_low, output int busy_ry);
    start_in = 1'b1; tick(); start_in = 1'b0;
    feed(stall, busy, lat, rdy_low, busy_ry);
  endtask

  task automatic do_read(input int addr, output int d18, output int d10, output bit v18, output bit v10);
    read_n = 1'b0; r_addr = 8'(addr);
    tick();
    d18 = int'(read_data); d10 = int'(read_data10); v18 = ry; v10 = ry10;
    read_n = 1'b1;
  endtask

  task automatic check_rows(input string tag);
    int d18, d10, e18, e10; bit v18, v10;
    for (int k = 0; k < 4; k++) begin
      int a = (k + int'($urandom_range(0, 3))) % 4;
      do_read(a, d18, d10, v18, v10);
      e18 = model_row(a, 18); e10 = model_row(a, 10);
      n_vec++; if (!v18 || d18 !== e18) begin n_err++; $display("FAIL %s row%0d: got ry=%0d data=%0d expected ry=1 data=%0d", tag, a, v18, d18, e18); end
      n_vec++; if (!v10 || d10 !== e10) begin n_err++; $display("FAIL %s res10 row%0d: got ry=%0d data=%0d expected ry=1 data=%0d", tag, a, v10, d10, e10); end
    end
    tick();
    n_vec++; if (ry !== 1'b0) begin n_err++; $display("FAIL %s ry_pulse: got %0d expected 0", tag, ry); end
  endtask

  task automatic test_reset();
    int d18, d10; bit v18, v10;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_vec++; if ({finish, load_ready, ry} !== 3'b000 || read_data !== 18'd0) begin
      n_err++; $display("FAIL reset_outs: got fin=%0d rdy=%0d ry=%0d data=%0d expected all 0", finish, load_ready, ry, read_data);
    end
    n_vec++; if ({finish10, load_ready10, ry10} !== 3'b000 || read_data10 !== 10'd0) begin
      n_err++; $display("FAIL reset_outs10: got fin=%0d rdy=%0d ry=%0d data=%0d expected all 0", finish10, load_ready10, ry10, read_data10);
    end
    for (int a = 0; a < 4; a++) begin
      do_read(a, d18, d10, v18, v10);
      n_vec++; if (!v18 || d18 !== 0) begin n_err++; $display("FAIL reset_mem row%0d: got ry=%0d data=%0d expected ry=1 data=0", a, v18, d18); end
    end
  endtask

  task automatic test_basic();
    int lat, rl, br;
    set_fixed();
    n_vec++; if (model_row(1, 18) !== 2550 || model_row(3, 18) !== 20) begin n_err++; $display("FAIL model_sanity: got %0d %0d expected 2550 20", model_row(1, 18), model_row(3, 18)); end
    start_in = 1'b1; tick(); start_in = 1'b0;
    n_vec++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL start_ready: got %0d expected 1", load_ready); end
    feed(1'b0, 1'b0, lat, rl, br);
    n_vec++; if (lat !== 17) begin n_err++; $display("FAIL basic_latency: got %0d expected 17", lat); end
    n_vec++; if (finish10 !== 1'b1) begin n_err++; $display("FAIL basic_finish10: got %0d expected 1", finish10); end
    check_rows("basic");
  endtask

  task automatic test_random();
    int lat, rl, br;
    for (int it = 0; it < 3; it++) begin
      set_random();
      run_load(1'b0, 1'b0, lat, rl, br);
      n_vec++; if (lat !== 17) begin n_err++; $display("FAIL random_latency: got %0d expected 17", lat); end
      check_rows("random");
    end
  endtask

  task automatic test_stall();
    int lat, rl, br;
    set_fixed();
    run_load(1'b1, 1'b0, lat, rl, br);
    n_vec++; if (rl !== 0) begin n_err++; $display("FAIL stall_ready: got %0d low cycles expected 0", rl); end
    n_vec++; if (lat !== 17) begin n_err++; $display("FAIL stall_latency: got %0d expected 17", lat); end
    check_rows("stall");
  endtask

  task automatic test_busy();
    int lat, rl, br, d18, d10; bit v18, v10;
    set_random();
    run_load(1'b0, 1'b1, lat, rl, br);
    n_vec++; if (br !== 0) begin n_err++; $display("FAIL busy_ry: got %0d strobes expected 0", br); end
    n_vec++; if (lat !== 17) begin n_err++; $display("FAIL busy_latency: got %0d expected 17", lat); end
    do_read(7, d18, d10, v18, v10);
    n_vec++; if (!v18 || d18 !== 0) begin n_err++; $display("FAIL addr7: got ry=%0d data=%0d expected ry=1 data=0", v18, d18); end
    check_rows("busy");
  endtask

  task automatic test_reset_mid();
    int lat, rl, br, d18, d10; bit v18, v10;
    set_random();
    start_in = 1'b1; tick(); start_in = 1'b0;
    for (int w = 0; w < 9; w++) begin
      valid_input = 1'b1;
      X_load = (w < 4) ? 8'(mc[w]) : 8'(mx[(w - 4) / 4][(w - 4) % 4]);
      tick();
    end
    valid_input = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    n_vec++; if (finish !== 1'b0 || load_ready !== 1'b0) begin n_err++; $display("FAIL midreset_outs: got fin=%0d rdy=%0d expected 0 0", finish, load_ready); end
    for (int a = 0; a < 4; a++) begin
      do_read(a, d18, d10, v18, v10);
      n_vec++; if (!v18 || d18 !== 0 || d10 !== 0) begin n_err++; $display("FAIL midreset_mem row%0d: got ry=%0d data=%0d/%0d expected ry=1 data=0", a, v18, d18, d10); end
    end
    set_random();
    run_load(1'b0, 1'b0, lat, rl, br);
    n_vec++; if (lat !== 17) begin n_err++; $display("FAIL fresh_latency: got %0d expected 17", lat); end
    check_rows("fresh");
  endtask

  task automatic test_restart_read();
    int lat, rl, br, old2;
    old2 = model_row(2, 18);
    start_in = 1'b1; read_n = 1'b0; r_addr = 8'd2;
    tick();
    start_in = 1'b0; read_n = 1'b1;
    n_vec++; if (ry !== 1'b1 || read_data !== 18'(old2)) begin n_err++; $display("FAIL restart_read: got ry=%0d data=%0d expected ry=1 data=%0d", ry, read_data, old2); end
    n_vec++; if (finish !== 1'b0 || load_ready !== 1'b1) begin n_err++; $display("FAIL restart_state: got fin=%0d rdy=%0d expected 0 1", finish, load_ready); end
    set_random();
    feed(1'b0, 1'b0, lat, rl, br);
    n_vec++; if (lat !== 17) begin n_err++; $display("FAIL restart_latency: got %0d expected 17", lat); end
    check_rows("restart");
  endtask

  initial begin
    rst = 1'b1; start_in = 1'b0; valid_input = 1'b0; read_n = 1'b1; X_load = 8'd0; r_addr = 8'd0;
    test_reset();
    test_basic();
    test_random();
    test_stall();
    test_busy();
    test_reset_mid();
    test_restart_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
